dma_dispatch: RTL and testbench

DMA_DISPATCH -- requirements
Module: dma_dispatch

---
 rtl/dma_dispatch.sv | 176 +++++++++++++++++
 tb/tb_dma_dispatch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_dispatch.sv
// dma_dispatch: instruction queue feeding a single-outstanding DMA issue FSM.
// Entries {write, addr, data} are buffered in a circular FIFO. One entry at a
// time is popped, strobed to the engine, and then tracked through its
// acknowledge (busy rising) and completion (busy falling).
module dma_dispatch #(
  parameter int DATA_W      = 18,
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_write,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      dma_we,
  output logic                      dma_re,
  output logic [ADDR_W-1:0]         dma_dat_addr,
  output logic [DATA_W-1:0]         dma_dat_w,
  input  logic                      dma_busy,
  output logic                      freeze,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               issued_cnt,
  output logic                      ack_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               full, empty, push, pop;
  entry_t             head;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  // Readiness depends only on occupancy, so a full queue drops a push even
  // when the FSM pops in the same cycle.
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // Queue storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{wr: in_write, addr: in_addr, data: in_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Issue FSM: pop on IDLE->ISSUE, strobe in ISSUE, then track ack and done.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !dma_busy) begin
          pop     = 1'b1;
          wr_d    = head.wr;
          addr_d  = head.addr;
          data_d  = head.data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (dma_busy) begin
          state_d = WAIT_DONE;
        end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Engine never acknowledged: flag it and drop the instruction.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!dma_busy) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous reset; reset discards queue and in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      tmr_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Queue payload needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready     = !full;
  assign dma_we       = (state_q == ISSUE) &&  wr_q;
  assign dma_re       = (state_q == ISSUE) && !wr_q;
  assign dma_dat_addr = addr_q;
  assign dma_dat_w    = data_q;
  assign freeze       = empty || (state_q != IDLE) || dma_busy;
  assign level        = level_q;
  assign issued_cnt   = cnt_q;
  assign ack_err      = err_q;

endmodule

// File: tb/tb_dma_dispatch.sv
// Bench for dma_dispatch: queue-based reference model compared every cycle,
// a DMA engine responder, directed scenarios with literal expectations and a
// randomized soak.
module tb_dma_dispatch;
  localparam int DATA_W = 18, ADDR_W = 7, DEPTH = 8, ACK_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0, in_write = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, dma_we, dma_re, freeze, ack_err;
  logic [ADDR_W-1:0] dma_dat_addr;
  logic [DATA_W-1:0] dma_dat_w;
  logic              dma_busy = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]       issued_cnt;

  dma_dispatch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_write(in_write),
    .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .dma_we(dma_we), .dma_re(dma_re), .dma_dat_addr(dma_dat_addr),
    .dma_dat_w(dma_dat_w), .dma_busy(dma_busy), .freeze(freeze),
    .level(level), .issued_cnt(issued_cnt), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              wr;
    bit [ADDR_W-1:0] addr;
    bit [DATA_W-1:0] data;
  } ent_t;

  ent_t            m_q[$];
  int              m_st = 0;      // 0 idle, 1 strobing, 2 awaiting ack, 3 awaiting done
  int              m_wait = 0;
  ent_t            m_cur;
  bit [ADDR_W-1:0] m_addr = '0;
  bit [DATA_W-1:0] m_data = '0;
  bit [15:0]       m_cnt = '0;
  bit              m_err = 1'b0;

  always @(posedge clk) begin
    bit   do_push;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_st = 0; m_wait = 0; m_addr = '0; m_data = '0; m_cnt = '0; m_err = 1'b0;
      m_cur = '{wr: 1'b0, addr: '0, data: '0};
    end else begin
      do_push = in_valid && (m_q.size() != DEPTH);
      e = '{wr: in_write, addr: in_addr, data: in_data};
      case (m_st)
        0: if (m_q.size() != 0 && !dma_busy) begin
             m_cur = m_q.pop_front();
             m_addr = m_cur.addr; m_data = m_cur.data;
             m_st = 1;
           end
        1: begin m_st = 2; m_wait = 0; end
        2: if (dma_busy) m_st = 3;
           else begin
             m_wait++;
             if (m_wait == ACK_TIMEOUT) begin m_err = 1'b1; m_st = 0; end
           end
        default: if (!dma_busy) begin m_cnt++; m_st = 0; end
      endcase
      if (do_push) m_q.push_back(e);
    end
  end

  // ---------------- DMA engine responder ----------------
  int mode = 0;       // 0 respond 1 cycle after strobe for resp_len; 1 never; 2 held high; 3 random
  int resp_len = 10;
  int busy_left = 0;
  bit strobe_neg = 1'b0;

  always @(posedge clk) begin
    #1;
    case (mode)
      0: begin
        if (strobe_neg) busy_left = resp_len;
        if (busy_left > 0) begin dma_busy = 1'b1; busy_left--; end
        else dma_busy = 1'b0;
      end
      1: dma_busy = 1'b0;
      2: dma_busy = 1'b1;
      default: dma_busy = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    strobe_neg = dma_we | dma_re;
    if (chk_en) begin
      chk("in_ready",   in_ready,     m_q.size() != DEPTH);
      chk("level",      level,        m_q.size());
      chk("freeze",     freeze,       (m_q.size() == 0) || (m_st != 0) || dma_busy);
      chk("dma_we",     dma_we,       (m_st == 1) && m_cur.wr);
      chk("dma_re",     dma_re,       (m_st == 1) && !m_cur.wr);
      chk("dat_addr",   dma_dat_addr, m_addr);
      chk("dat_w",      dma_dat_w,    m_data);
      chk("issued_cnt", issued_cnt,   m_cnt);
      chk("ack_err",    ack_err,      m_err);
    end
  end

  // ---------------- directed + random stimulus ----------------
  int we_cnt = 0, re_cnt = 0;
  int obs[$];

  task automatic step();
    @(negedge clk);
    we_cnt += int'(dma_we);
    re_cnt += int'(dma_re);
    if (dma_we || dma_re) obs.push_back(int'(dma_dat_addr));
  endtask

  task automatic drive(input bit v, input bit w, input int a, input int d);
    in_valid = v; in_write = w;
    in_addr = ADDR_W'(a); in_data = DATA_W'(d);
  endtask

  task automatic wait_strobe(input string name, input int bound);
    int n;
    n = 0;
    while (!(dma_we || dma_re) && n < bound) begin step(); n++; end
    if (n >= bound) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int pushes;
    // reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_freeze", freeze, 1);
    chk("rst_we", dma_we, 0);
    chk("rst_re", dma_re, 0);
    chk("rst_addr", dma_dat_addr, 0);
    chk("rst_cnt", issued_cnt, 0);
    chk("rst_err", ack_err, 0);
    reset = 1'b0;
    step();

    // single write, minimum latency
    mode = 0; resp_len = 10; we_cnt = 0;
    drive(1, 1, 120, 34133);
    step(); drive(0, 0, 0, 0);
    chk("t1_level_n1", level, 1);
    chk("t1_we_n1", dma_we, 0);
    step();
    chk("t1_we_n2", dma_we, 1);
    chk("t1_addr", dma_dat_addr, 120);
    chk("t1_data", dma_dat_w, 34133);
    repeat (20) step();
    chk("t1_we_pulses", we_cnt, 1);
    chk("t1_issued", issued_cnt, 1);

    // fill past full with busy held, then drain in order
    mode = 2; step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 1'(i % 2), 16 + i, i * 7 + 1);
      step();
    end
    drive(0, 0, 0, 0);
    chk("t2_level_full", level, DEPTH);
    chk("t2_ready_full", in_ready, 0);
    obs.delete();
    mode = 0; resp_len = 2;
    repeat (120) step();
    chk("t2_strobes", obs.size(), DEPTH);
    for (int k = 0; k < obs.size() && k < DEPTH; k++) chk("t2_order", obs[k], 16 + k);
    chk("t2_issued", issued_cnt, 9);

    // single read
    we_cnt = 0; re_cnt = 0;
    drive(1, 0, 5, 777);
    step(); drive(0, 0, 0, 0);
    repeat (20) step();
    chk("t3_re_pulses", re_cnt, 1);
    chk("t3_we_pulses", we_cnt, 0);
    chk("t3_addr", dma_dat_addr, 5);

    // acknowledge timeout
    mode = 1;
    drive(1, 1, 10, 100); step();
    drive(1, 0, 11, 200); step();
    drive(0, 0, 0, 0);
    wait_strobe("t4_first", 10);
    chk("t4_first_addr", dma_dat_addr, 10);
    repeat (ACK_TIMEOUT) step();
    chk("t4_err_before", ack_err, 0);
    step();
    chk("t4_err_after", ack_err, 1);
    chk("t4_issued", issued_cnt, 10);
    wait_strobe("t4_next", 10);
    chk("t4_next_addr", dma_dat_addr, 11);
    repeat (20) step();
    chk("t4_err_sticky", ack_err, 1);
    chk("t4_issued_end", issued_cnt, 10);

    // reset while waiting for done with entries queued
    mode = 0; resp_len = 20;
    for (int i = 0; i < 4; i++) begin drive(1, 1, 40 + i, i); step(); end
    drive(0, 0, 0, 0);
    repeat (6) step();
    chk("t5_level_pre", level, 3);
    chk("t5_freeze_pre", freeze, 1);
    reset = 1'b1;
    drive(1, 1, 99, 99);
    step();
    chk("t5_level", level, 0);
    chk("t5_issued", issued_cnt, 0);
    chk("t5_err", ack_err, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_addr", dma_dat_addr, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    we_cnt = 0; re_cnt = 0;
    repeat (30) step();
    chk("t5_no_strobe", we_cnt + re_cnt, 0);
    chk("t5_level_post", level, 0);

    // steady level with push-on-pop, wrapping pointers several times
    mode = 2; step();
    for (int i = 0; i < 4; i++) begin drive(1, 1'(i % 2), 60 + i, $urandom); step(); end
    drive(0, 0, 0, 0);
    chk("t6_level4", level, 4);
    mode = 0; resp_len = 1;
    pushes = 0;
    for (int n = 0; n < 1000 && pushes < 3 * DEPTH; n++) begin
      if (m_st == 0 && m_q.size() != 0 && !dma_busy) begin
        drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom);
        pushes++;
      end else drive(0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    chk("t6_pushes", pushes, 3 * DEPTH);
    chk("t6_level_hold", level, 4);
    repeat (60) step();
    chk("t6_drained", level, 0);
    chk("t6_issued", issued_cnt, 4 + 3 * DEPTH);

    // random soak
    for (int n = 0; n < 3000; n++) begin
      if (n % 300 == 0) begin
        mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 3);
        resp_len = $urandom_range(1, 5);
      end
      reset = ($urandom_range(0, 599) == 0);
      drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 127), $urandom);
      step();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
